bm_buf_free_list: RTL and testbench
===================================

// Module: bm_buf_free_list
// PURPOSE
// - Free-buffer pool for the buffer manager; sits directly downstream of bm_buf_release.
// - Holds all free buffer pointers in a circular RAM FIFO; returns pointers from bm_buf_release and hands them to allocators.
// - After reset, seeds the pool with every pointer and drives init_read_count_* to clear each buffer's release counter.
// - Tracks buffers in use per port.
// PARAMETERS
// - PTR_NBITS   10 (`BUF_PTR_NBITS)  buffer pointer width; NUM_BUF = 2**PTR_NBITS
// - PORT_NBITS  3  (`PORT_ID_NBITS)  port id width; NUM_PORTS = 2**PORT_NBITS
// - LOW_WM      16  low-watermark threshold (used only with BM_FREE_LIST_LOW_WM_EN)
// PORTS
// - clk                 in   1             clock
// - `RESET_SIG          in   1             asynchronous active-low reset
// - rel_buf_valid       in   1             release strobe from bm_buf_release
// - rel_buf_port_id     in   PORT_NBITS    port that owned the released buffer
// - rel_buf_ptr         in   PTR_NBITS     released pointer
// - alloc_req           in   1             allocation request, taken when alloc_req&alloc_ready
// - alloc_port_id       in   PORT_NBITS    requesting port
// - alloc_ready         out  1             pool can accept alloc_req this cycle
// - alloc_valid         out  1             allocated pointer valid
// - alloc_ptr           out  PTR_NBITS     allocated pointer
// - init_read_count_valid out 1            counter-clear strobe to bm_buf_release
// - init_read_count_ptr out  PTR_NBITS     pointer whose counter is cleared
// - init_done           out  1             seeding complete
// - free_count          out  PTR_NBITS+1   free pointers in pool
// - port_stat_sel       in   PORT_NBITS    port whose usage is reported
// - port_stat_count     out  PTR_NBITS+1   buffers in use by port_stat_sel, one cycle after sel
// - err_overflow        out  1             sticky: release with pool full, or release during INIT
// - err_underflow       out  1             sticky: release for a port whose usage is 0
// - free_low            out  1             (BM_FREE_LIST_LOW_WM_EN only) low-watermark flag
// BEHAVIOUR
// - Reset: every output, rd/wr pointers, free_count and all port counters go to 0; err flags clear; FSM goes to INIT.
// - FSM INIT: cycle k after reset release writes pointer k to RAM address k and drives init_read_count_valid=1, init_read_count_ptr=k.
//   After k=NUM_BUF-1: wr_ptr wraps to 0, free_count=NUM_BUF, FSM goes to RUN, init_done=1. INIT takes exactly NUM_BUF cycles.
// - RUN: alloc_ready = (free_count!=0), from registered count only; 0 in INIT.
// - Alloc accepted in cycle t: RAM read at rd_ptr in t; alloc_valid=1 and alloc_ptr at t+2 (registered); rd_ptr++ (wraps mod NUM_BUF).
//   Back-to-back accepts give one pointer per cycle; port_used[alloc_port_id]++.
// - Release in cycle t: write rel_buf_ptr at wr_ptr; wr_ptr++ (wraps); port_used[rel_buf_port_id]--.
//   The pointer is allocatable by a read issued at t+1 or later; no same-cycle bypass (alloc_ready is 0 when the pool is empty).
// - Simultaneous alloc+release: free_count unchanged; the two port counters update independently.
//   If both name the same port, the net port count is unchanged.
// - Release when free_count==NUM_BUF (no concurrent alloc): drop, set err_overflow, no pointer/count change.
// - Release during INIT: drop, set err_overflow.
// - Release to a port with count 0: count stays 0 (saturate), set err_underflow; the pointer is still returned to the pool.
// - Counts: free_count range 0..NUM_BUF, never wraps; port counters saturate at 0 and at NUM_BUF.
// - Reset mid-INIT or mid-RUN: immediate return to reset state; INIT restarts from pointer 0; in-flight alloc_valid is cancelled.
// - Pointer uniqueness is the caller's responsibility; duplicate releases are not detected.
// CONFIGURATION
// - BM_FREE_LIST_LOW_WM_EN defined: free_low is registered, =1 in RUN when free_count<LOW_WM, updates 1 cycle after the count.
// - BM_FREE_LIST_LOW_WM_EN undefined: the free_low port and its logic are absent.
// TESTING
// - Reset release -> 1024 init_read_count_valid pulses with ptr 0..1023, then init_done=1, free_count=1024, alloc_ready=1.
// - 3 back-to-back alloc_req port 2 after init -> alloc_ptr 0,1,2 on consecutive cycles from t+2; port_stat_count(2)=3; free_count=1021.
// - Drain pool to 0 -> alloc_ready=0; release ptr 5 -> next cycle alloc_ready=1; alloc -> alloc_ptr=5.
// - Alloc and release (ptr 7, port 2) in the same cycle with free_count=10 -> free_count stays 10; port 2 count unchanged.
// - Release with free_count=1024 -> err_overflow=1, free_count=1024; release on a port with count 0 -> err_underflow=1, free_count+1.
// - Assert reset at INIT pointer 500 -> after release INIT restarts at ptr 0 and completes at ptr 1023.
//   LOW_WM_EN build: free_count 16->15 -> free_low=1 one cycle later.

Source files
------------

// File: rtl/bm_buf_free_list_if.sv
// Allocation and release handshake between bm_buf_free_list, bm_buf_release and the allocators.
// The master drives releases and allocation requests. The slave is the free-list pool.
interface bm_buf_free_list_if #(
  parameter int unsigned PTR_NBITS  = 10,
  parameter int unsigned PORT_NBITS = 3
);
  logic                  rel_buf_valid;
  logic [PORT_NBITS-1:0] rel_buf_port_id;
  logic [PTR_NBITS-1:0]  rel_buf_ptr;
  logic                  alloc_req;
  logic [PORT_NBITS-1:0] alloc_port_id;
  logic                  alloc_ready;
  logic                  alloc_valid;
  logic [PTR_NBITS-1:0]  alloc_ptr;

  modport master (
    output rel_buf_valid, rel_buf_port_id, rel_buf_ptr, alloc_req, alloc_port_id,
    input  alloc_ready, alloc_valid, alloc_ptr
  );

  modport slave (
    input  rel_buf_valid, rel_buf_port_id, rel_buf_ptr, alloc_req, alloc_port_id,
    output alloc_ready, alloc_valid, alloc_ptr
  );
endinterface

// File: rtl/bm_buf_free_list.sv
// Free-buffer pool: a circular RAM FIFO of free pointers, seeded after reset, with per-port usage.
// Optional low-watermark flag o_free_low is built when BM_FREE_LIST_LOW_WM_EN is defined.
module bm_buf_free_list #(
  parameter int unsigned PTR_NBITS  = 10,
  parameter int unsigned PORT_NBITS = 3
`ifdef BM_FREE_LIST_LOW_WM_EN
  ,
  parameter int unsigned LOW_WM     = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bm_buf_free_list_if.slave    bus,
  output logic                 o_init_read_count_valid,
  output logic [PTR_NBITS-1:0] o_init_read_count_ptr,
  output logic                 o_init_done,
  output logic [PTR_NBITS:0]   o_free_count,
  input  logic [PORT_NBITS-1:0] i_port_stat_sel,
  output logic [PTR_NBITS:0]   o_port_stat_count,
  output logic                 o_err_overflow,
  output logic                 o_err_underflow
`ifdef BM_FREE_LIST_LOW_WM_EN
  ,
  output logic                 o_free_low
`endif
);
  localparam int unsigned NUM_BUF   = 2 ** PTR_NBITS;
  localparam int unsigned NUM_PORTS = 2 ** PORT_NBITS;
  localparam int unsigned CNT_NBITS = PTR_NBITS + 1;
  localparam logic [CNT_NBITS-1:0] FULL     = CNT_NBITS'(NUM_BUF);
  localparam logic [PTR_NBITS-1:0] LAST_PTR = PTR_NBITS'(NUM_BUF - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               r_state;
  logic [PTR_NBITS-1:0] r_init_ptr, r_rd_ptr, r_wr_ptr, r_rd_data, r_alloc_ptr, r_irc_ptr;
  logic [CNT_NBITS-1:0] r_free_count, r_port_stat;
  logic [CNT_NBITS-1:0] r_port_used [NUM_PORTS];
  logic [PTR_NBITS-1:0] r_mem [NUM_BUF];
  logic                 r_rd_valid, r_alloc_valid, r_irc_valid, r_init_done, r_err_ovf, r_err_udf;

  logic                 w_run, w_alloc_acc, w_rel_acc, w_rel_drop, w_same_port, w_mem_we;
  logic [PTR_NBITS-1:0] w_mem_addr, w_mem_wdata;

  assign w_run          = (r_state == StRun);
  assign bus.alloc_ready = w_run && (r_free_count != '0);
  assign w_alloc_acc    = bus.alloc_req && bus.alloc_ready;
  // A release into a full pool is only legal when an allocation frees a slot in the same cycle.
  assign w_rel_drop     = bus.rel_buf_valid && (!w_run || (r_free_count == FULL && !w_alloc_acc));
  assign w_rel_acc      = bus.rel_buf_valid && !w_rel_drop;
  assign w_same_port    = w_alloc_acc && w_rel_acc && (bus.alloc_port_id == bus.rel_buf_port_id);

  assign bus.alloc_valid        = r_alloc_valid;
  assign bus.alloc_ptr          = r_alloc_ptr;
  assign o_init_read_count_valid = r_irc_valid;
  assign o_init_read_count_ptr  = r_irc_ptr;
  assign o_init_done            = r_init_done;
  assign o_free_count           = r_free_count;
  assign o_port_stat_count      = r_port_stat;
  assign o_err_overflow         = r_err_ovf;
  assign o_err_underflow        = r_err_udf;

  // Seeding and releases share the single RAM write port.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_wr_ptr;
    w_mem_wdata = bus.rel_buf_ptr;
    if (!w_run) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_ptr;
      w_mem_wdata = r_init_ptr;
    end else if (w_rel_acc) begin
      w_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StInit;
      r_init_ptr    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_free_count  <= '0;
      r_rd_valid    <= 1'b0;
      r_alloc_valid <= 1'b0;
      r_alloc_ptr   <= '0;
      r_irc_valid   <= 1'b0;
      r_irc_ptr     <= '0;
      r_init_done   <= 1'b0;
      r_port_stat   <= '0;
      r_err_ovf     <= 1'b0;
      r_err_udf     <= 1'b0;
    end else begin
      r_rd_valid    <= w_alloc_acc;
      r_alloc_valid <= r_rd_valid;
      if (r_rd_valid) r_alloc_ptr <= r_rd_data;
      r_port_stat <= r_port_used[i_port_stat_sel];
      if (w_rel_drop) r_err_ovf <= 1'b1;
      if (w_rel_acc && !w_same_port && r_port_used[bus.rel_buf_port_id] == '0) r_err_udf <= 1'b1;
      case (r_state)
        StInit: begin
          r_irc_valid <= 1'b1;
          r_irc_ptr   <= r_init_ptr;
          r_init_ptr  <= r_init_ptr + 1'b1;
          if (r_init_ptr == LAST_PTR) begin
            r_state      <= StRun;
            r_free_count <= FULL;
            r_init_done  <= 1'b1;
            r_wr_ptr     <= '0;
          end
        end
        StRun: begin
          r_irc_valid <= 1'b0;
          if (w_alloc_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_rel_acc)   r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_alloc_acc && !w_rel_acc)      r_free_count <= r_free_count - 1'b1;
          else if (w_rel_acc && !w_alloc_acc) r_free_count <= r_free_count + 1'b1;
        end
        default: r_state <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) r_port_used[i] <= '0;
    end else if (!w_same_port) begin
      if (w_alloc_acc && r_port_used[bus.alloc_port_id] != FULL)
        r_port_used[bus.alloc_port_id] <= r_port_used[bus.alloc_port_id] + 1'b1;
      if (w_rel_acc && r_port_used[bus.rel_buf_port_id] != '0)
        r_port_used[bus.rel_buf_port_id] <= r_port_used[bus.rel_buf_port_id] - 1'b1;
    end
  end

`ifdef BM_FREE_LIST_LOW_WM_EN
  logic r_free_low;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free_low <= 1'b0;
    else        r_free_low <= w_run && (r_free_count < CNT_NBITS'(LOW_WM));
  end
  assign o_free_low = r_free_low;
`endif
endmodule

// File: tb/tb_bm_buf_free_list.sv
// Randomized bench for bm_buf_free_list, checked against a queue-based model of the free pool.
module tb_bm_buf_free_list;
  localparam int NUM_BUF   = 1024;
  localparam int NUM_PORTS = 8;
  localparam int LOW_WM    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irc_v, init_done, eo, eu;
  logic [9:0]  irc_ptr;
  logic [10:0] free_count, stat_cnt;
  logic [2:0]  stat_sel;
`ifdef BM_FREE_LIST_LOW_WM_EN
  logic        free_low;
`endif

  always #5 clk = ~clk;

  bm_buf_free_list_if #(.PTR_NBITS(10), .PORT_NBITS(3)) bus ();

  bm_buf_free_list #(.PTR_NBITS(10), .PORT_NBITS(3)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .bus                     (bus),
    .o_init_read_count_valid (irc_v),
    .o_init_read_count_ptr   (irc_ptr),
    .o_init_done             (init_done),
    .o_free_count            (free_count),
    .i_port_stat_sel         (stat_sel),
    .o_port_stat_count       (stat_cnt),
    .o_err_overflow          (eo),
    .o_err_underflow         (eu)
`ifdef BM_FREE_LIST_LOW_WM_EN
    ,
    .o_free_low              (free_low)
`endif
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: the pool is a plain FIFO of pointers.
  typedef struct {int due; int ptr;} pend_t;
  int    m_free, cyc;
  bit    m_run, m_ovf, m_udf;
  int    m_used [NUM_PORTS];
  int    m_pool [$];
  pend_t m_pend [$];

  task automatic model_seed(input bit ovf);
    m_run = 1; m_free = NUM_BUF; m_ovf = ovf; m_udf = 0; cyc = 0;
    m_pool.delete(); m_pend.delete();
    for (int i = 0; i < NUM_BUF; i++) m_pool.push_back(i);
    for (int i = 0; i < NUM_PORTS; i++) m_used[i] = 0;
  endtask

  task automatic step(input bit req, input int aport, input bit rv, input int rport,
                      input int rptr, input int sel);
    bit acc, racc, exp_low;
    int exp_stat;
    pend_t p;
    bus.alloc_req = req; bus.alloc_port_id = 3'(aport);
    bus.rel_buf_valid = rv; bus.rel_buf_port_id = 3'(rport); bus.rel_buf_ptr = 10'(rptr);
    stat_sel = 3'(sel);
    exp_stat = m_used[sel];
    exp_low = m_run && (m_free < LOW_WM);
    acc = m_run && req && (m_free > 0);
    racc = 0;
    if (rv) begin
      if (!m_run || (m_free == NUM_BUF && !acc)) m_ovf = 1;
      else racc = 1;
    end
    if (acc) begin
      p.due = cyc + 2;
      p.ptr = m_pool.pop_front();
      m_pend.push_back(p);
    end
    if (racc) m_pool.push_back(rptr);
    if (!(acc && racc && aport == rport)) begin
      if (acc && m_used[aport] < NUM_BUF) m_used[aport]++;
      if (racc) begin
        if (m_used[rport] == 0) m_udf = 1;
        else m_used[rport]--;
      end
    end
    m_free = m_free + int'(racc) - int'(acc);
    @(negedge clk);
    cyc++;
    check_val("free_count", free_count, m_free);
    check_val("alloc_ready", bus.alloc_ready, (m_run && m_free > 0));
    check_val("err_overflow", eo, m_ovf);
    check_val("err_underflow", eu, m_udf);
    check_val("port_stat", stat_cnt, exp_stat);
    check_val("irc_idle", irc_v, 0);
    if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
      p = m_pend.pop_front();
      check_val("alloc_valid", bus.alloc_valid, 1);
      check_val("alloc_ptr", bus.alloc_ptr, p.ptr);
    end else begin
      check_val("alloc_valid", bus.alloc_valid, 0);
    end
`ifdef BM_FREE_LIST_LOW_WM_EN
    check_val("free_low", free_low, exp_low);
`endif
  endtask

  task automatic idle(input int n, input int sel);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, sel);
  endtask

  // Follows one full seeding pass; optionally fires a release during it.
  task automatic run_init(input int inject_at, input bit exp_ovf);
    int k = 0;
    int n = 0;
    while (n < NUM_BUF + 20) begin
      bus.rel_buf_valid = (n == inject_at);
      bus.rel_buf_port_id = 3'd1;
      bus.rel_buf_ptr = 10'd33;
      @(negedge clk);
      n++;
      if (irc_v) begin
        check_val("init_ptr", irc_ptr, k);
        k++;
      end
      if (init_done) break;
    end
    bus.rel_buf_valid = 0;
    check_val("init_pulses", k, NUM_BUF);
    check_val("init_done", init_done, 1);
    check_val("init_free", free_count, NUM_BUF);
    check_val("init_ready", bus.alloc_ready, 1);
    check_val("init_ovf", eo, exp_ovf);
  endtask

  initial begin
    int guard;
    bus.alloc_req = 0; bus.alloc_port_id = 0; bus.rel_buf_valid = 0;
    bus.rel_buf_port_id = 0; bus.rel_buf_ptr = 0; stat_sel = 0;
    m_run = 0;
    repeat (3) @(negedge clk);
    check_val("rst_irc", irc_v, 0);
    check_val("rst_done", init_done, 0);
    check_val("rst_free", free_count, 0);
    check_val("rst_ready", bus.alloc_ready, 0);
    check_val("rst_avalid", bus.alloc_valid, 0);
    check_val("rst_errs", {eo, eu}, 0);
    check_val("rst_stat", stat_cnt, 0);
    rst_n = 1;

    // Reset in the middle of seeding at pointer 500.
    guard = 0;
    while (!(irc_v && irc_ptr == 10'd500) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_val("reach_500", irc_ptr, 500);
    rst_n = 0;
    #1;
    check_val("midinit_irc", irc_v, 0);
    check_val("midinit_free", free_count, 0);
    @(negedge clk);
    rst_n = 1;
    run_init(10, 1);

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    run_init(-1, 0);
    model_seed(0);

    step(0, 0, 1, 0, 77, 0);                    // release into a full pool
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 0, 2);
    idle(3, 2);
    check_val("free_after3", free_count, NUM_BUF - 3);
    step(0, 0, 1, 5, 1, 5);                     // port 5 owns nothing
    idle(2, 5);

    guard = 0;
    while (m_free > 0 && guard < 2000) begin
      step(1, $urandom_range(0, 7), 0, 0, 0, $urandom_range(0, 7));
      guard++;
    end
    idle(3, 0);
    check_val("drained_ready", bus.alloc_ready, 0);
    step(0, 0, 1, 2, 5, 2);
    step(1, 3, 0, 0, 0, 3);
    idle(3, 3);

    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 100 + i, 1);
    check_val("free_ten", free_count, 10);
    step(1, 2, 1, 2, 7, 2);
    idle(3, 2);
    check_val("free_sim", free_count, 10);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 50, $urandom_range(0, 7),
           $urandom_range(0, 99) < 45, $urandom_range(0, 7),
           $urandom_range(0, NUM_BUF - 1), $urandom_range(0, 7));
    end
    idle(4, 0);

    // Reset with an allocation in flight.
    m_free = m_free;
    bus.alloc_req = 1;
    @(posedge clk);
    #1;
    bus.alloc_req = 0;
    rst_n = 0;
    #1;
    check_val("rst_cancel_av", bus.alloc_valid, 0);
    check_val("rst_cancel_free", free_count, 0);
    @(negedge clk);
    check_val("rst_cancel_av2", bus.alloc_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
